// File: rtl/primus_mem_arbiter.sv
// Two-way memory port arbiter: instruction fetch vs. data (load/store), one
// outstanding transaction, data-priority with a streak cap so fetch always progresses.
module primus_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_gnt_o,
    output logic                if_rvalid_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    output logic                d_gnt_o,
    output logic                d_rvalid_o,
    output logic [DATA_W-1:0]   d_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

    state_t     state_q, state_d;
    logic [3:0] streak_q, streak_d;
    logic       d_win, if_win;

    // Data wins unless fetch is waiting and data has already had its full streak.
    assign d_win  = d_req_i && (!if_req_i || (streak_q < 4'(MAX_D_STREAK)));
    assign if_win = if_req_i && !d_win;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        if_gnt_o    = 1'b0;
        if_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        d_gnt_o     = 1'b0;
        d_rvalid_o  = 1'b0;
        d_rdata_o   = '0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            IDLE: begin
                if (d_win) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = d_we_i;
                    mem_be_o    = d_be_i;
                    mem_addr_o  = d_addr_i;
                    mem_wdata_o = d_wdata_i;
                    if (mem_gnt_i) begin
                        d_gnt_o = 1'b1;
                        state_d = WAIT_D;
                        if (if_req_i)
                            streak_d = (streak_q < 4'(MAX_D_STREAK)) ? streak_q + 4'd1 : streak_q;
                        else
                            streak_d = '0;
                    end
                end else if (if_win) begin
                    mem_req_o  = 1'b1;
                    mem_be_o   = '1;
                    mem_addr_o = if_addr_i;
                    if (mem_gnt_i) begin
                        if_gnt_o = 1'b1;
                        state_d  = WAIT_IF;
                        streak_d = '0;
                    end
                end
            end
            WAIT_IF: begin
                if (mem_rvalid_i) begin
                    if_rvalid_o = 1'b1;
                    if_rdata_o  = mem_rdata_i;
                    state_d     = IDLE;
                end
            end
            WAIT_D: begin
                if (mem_rvalid_i) begin
                    d_rvalid_o = 1'b1;
                    d_rdata_o  = mem_rdata_i;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            streak_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
        end
    end

endmodule

// File: tb/tb_primus_mem_arbiter.sv
// Directed bench for primus_mem_arbiter: the bench plays the memory, a scoreboard
// queue holds the response expected for each granted transaction.
module tb_primus_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_i, if_gnt_o, if_rvalid_o;
    logic [AW-1:0] if_addr_i;
    logic [DW-1:0] if_rdata_o;
    logic          d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
    logic [BW-1:0] d_be_i;
    logic [AW-1:0] d_addr_i;
    logic [DW-1:0] d_wdata_i, d_rdata_o;
    logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [BW-1:0] mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o, mem_rdata_i;

    primus_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(4)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
        .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            is_d;
        logic [DW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Inputs change just after the rising edge; memory strobes default back to idle.
    task automatic step();
        @(posedge clk);
        #1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic grant_chk(input bit exp_d, input logic [31:0] addr, input logic [31:0] data);
        mem_gnt_i = 1'b1;
        samp();
        chk1("mem_req", mem_req_o, 1'b1);
        chk1("d_gnt", d_gnt_o, exp_d);
        chk1("if_gnt", if_gnt_o, !exp_d);
        chk32("mem_addr", mem_addr_o, addr);
        sb.push_back(exp_t'{is_d: exp_d, data: data});
    endtask

    task automatic respond();
        exp_t e;
        if (sb.size() == 0) begin
            chk1("sb_nonempty", 1'b0, 1'b1);
            return;
        end
        e = sb.pop_front();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = e.data;
        samp();
        chk1("d_rvalid", d_rvalid_o, e.is_d);
        chk1("if_rvalid", if_rvalid_o, !e.is_d);
        chk32("d_rdata", d_rdata_o, e.is_d ? e.data : 32'h0);
        chk32("if_rdata", if_rdata_o, e.is_d ? 32'h0 : e.data);
    endtask

    initial begin
        string order;
        bit    expd;
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0;
        d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = '0; d_addr_i = '0; d_wdata_i = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;

        // Reset state
        samp();
        chk1("rst_mem_req", mem_req_o, 1'b0);
        chk1("rst_d_gnt", d_gnt_o, 1'b0);
        chk1("rst_if_gnt", if_gnt_o, 1'b0);
        chk1("rst_d_rvalid", d_rvalid_o, 1'b0);
        chk32("rst_mem_addr", mem_addr_o, 32'h0);
        step();
        rst = 1'b0;

        // Single load
        step();
        d_req_i = 1'b1; d_addr_i = 32'h100; d_be_i = 4'hF; d_we_i = 1'b0;
        grant_chk(1'b1, 32'h100, 32'hDEADBEEF);
        chk1("load_we", mem_we_o, 1'b0);
        step();
        d_req_i = 1'b0;
        samp();
        chk1("wait_mem_req", mem_req_o, 1'b0);
        chk1("wait_d_rvalid", d_rvalid_o, 1'b0);
        step();
        respond();

        // Store; a stray mem_gnt_i while waiting must not produce a grant
        step();
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'b0011; d_wdata_i = 32'h1234; d_addr_i = 32'h180;
        grant_chk(1'b1, 32'h180, 32'h0);
        chk1("st_we", mem_we_o, 1'b1);
        chk32("st_be", 32'(mem_be_o), 32'h3);
        chk32("st_wdata", mem_wdata_o, 32'h1234);
        step();
        mem_gnt_i = 1'b1;
        samp();
        chk1("wait_gnt_ignored", d_gnt_o, 1'b0);
        chk1("wait_no_req", mem_req_o, 1'b0);
        step();
        d_req_i = 1'b0; d_we_i = 1'b0;
        respond();

        // Contention with both requests held: four data grants, then one fetch
        step();
        if_req_i = 1'b1; if_addr_i = 32'h400;
        d_req_i = 1'b1; d_addr_i = 32'h200; d_be_i = 4'hF;
        order = "DDDDIDDDDI";
        for (int i = 0; i < 10; i++) begin
            expd = (order[i] == "D");
            grant_chk(expd, expd ? 32'h200 : 32'h400, 32'hA000 + 32'(i));
            if (!expd) begin
                chk32("if_be", 32'(mem_be_o), 32'hF);
                chk1("if_we", mem_we_o, 1'b0);
                chk32("if_wdata", mem_wdata_o, 32'h0);
            end
            step();
            step();
            respond();
            step();
        end
        if_req_i = 1'b0; d_req_i = 1'b0;

        // Grant stall: request and address held while mem_gnt_i stays low
        step();
        d_req_i = 1'b1; d_addr_i = 32'h300;
        for (int k = 0; k < 3; k++) begin
            samp();
            chk1("stall_req", mem_req_o, 1'b1);
            chk32("stall_addr", mem_addr_o, 32'h300);
            chk1("stall_no_gnt", d_gnt_o, 1'b0);
            step();
        end
        grant_chk(1'b1, 32'h300, 32'h3333);
        step();
        d_req_i = 1'b0;
        step();
        respond();

        // Reset while a data transaction is outstanding; its response is dropped
        step();
        d_req_i = 1'b1; d_addr_i = 32'h500;
        grant_chk(1'b1, 32'h500, 32'hBAD);
        void'(sb.pop_back());
        step();
        d_req_i = 1'b0;
        rst = 1'b1;
        samp();
        chk1("rstw_mem_req", mem_req_o, 1'b0);
        step();
        rst = 1'b0;
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
        samp();
        chk1("late_d_rvalid", d_rvalid_o, 1'b0);
        chk1("late_if_rvalid", if_rvalid_o, 1'b0);
        chk32("late_d_rdata", d_rdata_o, 32'h0);
        step();
        if_req_i = 1'b1; if_addr_i = 32'h600;
        grant_chk(1'b0, 32'h600, 32'h6666);
        step();
        if_req_i = 1'b0;
        step();
        respond();

        // Spurious response in IDLE with nobody requesting
        step();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55AA;
        samp();
        chk1("spur_d_rvalid", d_rvalid_o, 1'b0);
        chk1("spur_if_rvalid", if_rvalid_o, 1'b0);
        chk32("spur_d_rdata", d_rdata_o, 32'h0);
        chk32("spur_if_rdata", if_rdata_o, 32'h0);
        chk1("spur_mem_req", mem_req_o, 1'b0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
